// File: rtl/lab2_sweep.sv
// Sequential vector sweeper for the 3-input truth-table stage: drives x through 0..7,
// samples z/error after a settle time and reports the table. Optional macro: LAB2_SWEEP_LOCAL_CHECK_EN.
module lab2_sweep #(
    parameter int unsigned SETTLE = 1,
    parameter logic [7:0]  TRUTH  = 8'b00111001
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       z_in,
    input  logic       err_in,
    output logic [2:0] x,
    output logic       busy,
    output logic       done,
    output logic [7:0] captured,
    output logic [3:0] err_count,
    output logic       pass
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    localparam logic [7:0] RELOAD = 8'(SETTLE - 1);

    state_t     state_q, state_d;
    logic [2:0] x_q, x_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] captured_q, captured_d;
    logic [3:0] errCount_q, errCount_d;
    logic       pass_q, pass_d;
    logic       done_q, done_d;
    logic       busy_q, busy_d;
    logic       mismatch;

`ifdef LAB2_SWEEP_LOCAL_CHECK_EN
    // Local comparison also catches a stage whose own error output is stuck low.
    assign mismatch = err_in | (z_in != TRUTH[x_q]);
`else
    assign mismatch = err_in;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_SETTLE;
            ST_SETTLE: if (cnt_q == 8'd0) state_d = ST_SAMPLE;
            ST_SAMPLE: state_d = (x_q == 3'd7) ? ST_DONE : ST_SETTLE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Done is registered on the edge leaving DONE, so it pulses the cycle after that state.
    always_comb begin
        x_d        = x_q;
        cnt_d      = cnt_q;
        captured_d = captured_q;
        errCount_d = errCount_q;
        pass_d     = pass_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                x_d = 3'd0;
                if (start) begin
                    captured_d = 8'd0;
                    errCount_d = 4'd0;
                    pass_d     = 1'b0;
                    cnt_d      = RELOAD;
                end
            end
            ST_SETTLE: begin
                if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
            end
            ST_SAMPLE: begin
                captured_d[x_q] = z_in;
                if (mismatch) errCount_d = errCount_q + 4'd1;
                if (x_q != 3'd7) begin
                    x_d   = x_q + 3'd1;
                    cnt_d = RELOAD;
                end
            end
            ST_DONE: begin
                done_d = 1'b1;
                pass_d = (errCount_q == 4'd0) && (captured_q == TRUTH);
                x_d    = 3'd0;
            end
            default: x_d = 3'd0;
        endcase
        busy_d = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_q        <= 3'd0;
            cnt_q      <= 8'd0;
            captured_q <= 8'd0;
            errCount_q <= 4'd0;
            pass_q     <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            x_q        <= x_d;
            cnt_q      <= cnt_d;
            captured_q <= captured_d;
            errCount_q <= errCount_d;
            pass_q     <= pass_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign x         = x_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign captured  = captured_q;
    assign err_count = errCount_q;
    assign pass      = pass_q;

endmodule

// File: tb/tb_lab2_sweep.sv
// Self-checking bench for lab2_sweep: two instances (settle 1 and 3) driven by a
// table-based model of the logic stage; expectations come from the sweep's cycle rules.
module tb_lab2_sweep;

    localparam logic [7:0] TRUTH = 8'b00111001;
`ifdef LAB2_SWEEP_LOCAL_CHECK_EN
    localparam bit LOCAL = 1'b1;
`else
    localparam bit LOCAL = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       start1, start3;
    logic       z1, z3, e1, e3;
    logic [2:0] x1, x3;
    logic       busy1, busy3, done1, done3, pass1, pass3;
    logic [7:0] cap1, cap3;
    logic [3:0] ec1, ec3;

    logic [7:0] zTab, eTab;
    int         sel;
    logic [2:0] curX;
    logic       curBusy, curDone, curPass;
    logic [7:0] curCap;
    logic [3:0] curEc;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    lab2_sweep #(.SETTLE(1), .TRUTH(TRUTH)) u1 (
        .clock(clock), .reset(reset), .start(start1), .z_in(z1), .err_in(e1),
        .x(x1), .busy(busy1), .done(done1), .captured(cap1), .err_count(ec1), .pass(pass1)
    );

    lab2_sweep #(.SETTLE(3), .TRUTH(TRUTH)) u3 (
        .clock(clock), .reset(reset), .start(start3), .z_in(z3), .err_in(e3),
        .x(x3), .busy(busy3), .done(done3), .captured(cap3), .err_count(ec3), .pass(pass3)
    );

    // Combinational logic stage modelled as lookup tables indexed by the driven vector.
    always_comb begin
        z1 = zTab[x1];
        e1 = eTab[x1];
        z3 = zTab[x3];
        e3 = eTab[x3];
    end

    always_comb begin
        curX    = (sel == 3) ? x3    : x1;
        curBusy = (sel == 3) ? busy3 : busy1;
        curDone = (sel == 3) ? done3 : done1;
        curPass = (sel == 3) ? pass3 : pass1;
        curCap  = (sel == 3) ? cap3  : cap1;
        curEc   = (sel == 3) ? ec3   : ec1;
    end

    task automatic runSweep(input int settle, input int pokeX, input string tag);
        int         total;
        logic [7:0] expCap;
        int         expErr;
        bit         expPass;
        bit         poked;
        logic [4:0] expTrace;
        total  = 8 * (settle + 1);
        expCap = zTab;
        expErr = 0;
        for (int i = 0; i < 8; i++)
            if (eTab[i] || (LOCAL && (zTab[i] != TRUTH[i]))) expErr++;
        expPass = (expErr == 0) && (expCap == TRUTH);
        poked   = 1'b0;
        sel     = settle;
        @(negedge clock);
        if (settle == 3) start3 = 1'b1; else start1 = 1'b1;
        for (int e = 0; e <= total + 1; e++) begin
            @(negedge clock);
            start1 = 1'b0;
            start3 = 1'b0;
            if (e < total)       expTrace = {3'(e / (settle + 1)), 1'b1, 1'b0};
            else if (e == total) expTrace = {3'd7, 1'b0, 1'b0};
            else                 expTrace = {3'd0, 1'b0, 1'b1};
            checks++;
            if ({curX, curBusy, curDone} !== expTrace) begin
                errors++;
                $display("[TB] FAIL %s trace edge %0d: got x/busy/done=%b, want %b",
                         tag, e, {curX, curBusy, curDone}, expTrace);
            end
            if (e == 0) begin
                checks++;
                if ({curCap, curEc, curPass} !== 13'd0) begin
                    errors++;
                    $display("[TB] FAIL %s clear-on-start: got cap=%h ec=%0d pass=%b, want 0",
                             tag, curCap, curEc, curPass);
                end
            end
            if (pokeX >= 0 && !poked && curX == 3'(pokeX) && e < total) begin
                poked = 1'b1;
                if (settle == 3) start3 = 1'b1; else start1 = 1'b1;
            end
        end
        checks++;
        if (curCap !== expCap || curEc !== 4'(expErr) || curPass !== expPass) begin
            errors++;
            $display("[TB] FAIL %s results: got cap=%h ec=%0d pass=%b, want cap=%h ec=%0d pass=%b",
                     tag, curCap, curEc, curPass, expCap, expErr, expPass);
        end
        @(negedge clock);
        checks++;
        if (curDone !== 1'b0 || curBusy !== 1'b0 || curCap !== expCap || curPass !== expPass) begin
            errors++;
            $display("[TB] FAIL %s hold: got done=%b busy=%b cap=%h pass=%b, want 0 0 %h %b",
                     tag, curDone, curBusy, curCap, curPass, expCap, expPass);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if ({x1, busy1, done1, cap1, ec1, pass1, x3, busy3, done3, cap3, ec3, pass3} !== 38'd0) begin
            errors++;
            $display("[TB] FAIL reset values: got x1=%0d busy1=%b done1=%b cap1=%h ec1=%0d pass1=%b x3=%0d",
                     x1, busy1, done1, cap1, ec1, pass1, x3);
        end
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            checks++;
            if ({x1, busy1, done1, x3, busy3, done3} !== 10'd0) begin
                errors++;
                $display("[TB] FAIL idle cycle %0d: got x1=%0d busy1=%b done1=%b x3=%0d, want 0",
                         c, x1, busy1, done1, x3);
            end
        end
    endtask

    task automatic test_reset_wins();
        @(negedge clock);
        reset  = 1'b1;
        start1 = 1'b1;
        @(negedge clock);
        start1 = 1'b0;
        checks++;
        if (busy1 !== 1'b0 || x1 !== 3'd0) begin
            errors++;
            $display("[TB] FAIL reset_wins: got busy=%b x=%0d, want 0 0", busy1, x1);
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset_mid();
        int  waited;
        bit  sawDone;
        zTab = TRUTH;
        eTab = 8'd0;
        sel  = 1;
        @(negedge clock);
        start1 = 1'b1;
        @(negedge clock);
        start1 = 1'b0;
        waited = 0;
        while (x1 != 3'd5 && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        checks++;
        if (x1 !== 3'd5) begin
            errors++;
            $display("[TB] FAIL reset_mid wait: got x=%0d, want 5", x1);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({x1, busy1, done1, cap1, ec1, pass1} !== 19'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid async: got x=%0d busy=%b done=%b cap=%h ec=%0d pass=%b",
                     x1, busy1, done1, cap1, ec1, pass1);
        end
        sawDone = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (c == 2) reset = 1'b0;
            if (done1) sawDone = 1'b1;
        end
        checks++;
        if (sawDone !== 1'b0 || x1 !== 3'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid quiet: got done_seen=%b x=%0d, want 0 0", sawDone, x1);
        end
        runSweep(1, -1, "restart_after_reset");
    endtask

    task automatic test_fixed_patterns();
        zTab = TRUTH;  eTab = 8'd0;
        runSweep(1, -1, "ideal_s1");
        zTab = 8'd0;   eTab = TRUTH;
        runSweep(1, -1, "stuck0");
        zTab = ~TRUTH; eTab = 8'd0;
        runSweep(1, -1, "inverted");
        zTab = TRUTH;  eTab = 8'd0;
        runSweep(1, 3, "start_ignored");
        runSweep(3, -1, "ideal_s3");
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            zTab = 8'($urandom);
            eTab = 8'($urandom) & 8'($urandom);
            runSweep((r % 2 == 0) ? 1 : 3, -1, "random");
        end
    endtask

    initial begin
        reset  = 1'b1;
        start1 = 1'b0;
        start3 = 1'b0;
        zTab   = TRUTH;
        eTab   = 8'd0;
        sel    = 1;
        test_reset();
        test_fixed_patterns();
        test_reset_wins();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lab2_sweep.md
# lab2_sweep

Sequential vector sweeper and checker sitting directly upstream of the 3-input truth-table logic stage. On a start request it drives `x[2:0]` through all eight input combinations. It waits a programmable settle time per vector and samples the stage's returned `z` and `error` signals. When the sweep finishes it reports the observed 8-entry truth table, a mismatch count and a pass flag, signalled by a one-cycle done pulse.

## Interface
- `SETTLE`, 1: cycles each vector is held before sampling; legal range 1..255 (8-bit counter).
- `TRUTH`, 8'b00111001: expected table; bit i is the expected `z` for `x == i`.

- `clock`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  sweep request; sampled only in IDLE.
- `z_in`  in  1  `z` returned by the logic stage.
- `err_in`  in  1  `error` returned by the logic stage.
- `x`  out  3  vector driven to the logic stage.
- `busy`  out  1  high in SETTLE and SAMPLE.
- `done`  out  1  one-cycle pulse when the sweep completes.
- `captured`  out  8  observed table; bit i is `z_in` sampled at `x == i`.
- `err_count`  out  4  mismatches counted this sweep, 0..8.
- `pass`  out  1  registered; 1 iff `err_count == 0` and `captured == TRUTH`.

Reset values: `x = 0`, `busy = 0`, `done = 0`, `captured = 0`, `err_count = 0`, `pass = 0`, state = IDLE, settle counter = 0.

## Operation
- All outputs are registered. The FSM has four states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - `x = 0`.
  - If `start == 1` at a clock edge: clear `captured`, `err_count` and `pass`, load the counter with `SETTLE - 1`, and go to SETTLE.
- SETTLE:
  - Hold `x`.
  - If the counter is 0, go to SAMPLE; otherwise decrement the counter.
- SAMPLE (one cycle). At the edge ending this state:
  - `captured[x] <= z_in`.
  - `err_count` increments when a mismatch is detected (mismatch definition in Configuration).
  - If `x == 7`, go to DONE. Otherwise `x <= x + 1`, reload the counter with `SETTLE - 1`, and go to SETTLE.
- DONE (one cycle):
  - `done = 1`.
  - `pass` is loaded from the final `captured` and `err_count`.
  - Next state is IDLE, and `x` returns to 0.
- `start` is ignored in SETTLE, SAMPLE and DONE; no queuing.
- `captured`, `err_count` and `pass` hold their values from DONE until the next accepted start.
- `err_count` cannot exceed 8, so no saturation logic is needed; `x` never wraps.

## Timing
- The logic stage is combinational, so `z_in`/`err_in` are valid in the same cycle as `x`. `SETTLE >= 1` guarantees at least one full cycle of stability before sampling.
- Each vector occupies `SETTLE + 1` cycles (SETTLE cycles, then one SAMPLE cycle).
- With start accepted at edge 0, `done` is high in the cycle following edge `8*(SETTLE+1) + 1`.
  - `SETTLE = 1`: `done` after edge 17.
  - `SETTLE = 3`: `done` after edge 33.
- `x` changes only on the edge that leaves SAMPLE or DONE.
- Reset mid-sweep: all registers go to their reset values immediately, with no `done` pulse; the partial results are discarded.
- If `start` and `reset` are asserted together, reset wins.

## Configuration
- `LAB2_SWEEP_LOCAL_CHECK_EN`:
  - Defined: a mismatch in SAMPLE is `err_in | (z_in != TRUTH[x])`. This detects a stage whose own error output is broken.
  - Undefined: a mismatch is `err_in` only, and the `TRUTH` comparator is not built.
- `pass` always compares `captured` against `TRUTH` in both builds.

## Test plan
- Reset asserted, then released with `start` low → all outputs at reset values and `x` stays 0 for 20 cycles.
- Ideal stage (`z_in = TRUTH[x]`, `err_in = 0`), `SETTLE = 1`, one-cycle `start` → `x` steps 0..7, each value held 2 cycles; `done` after edge 17; `captured = 8'h39`, `err_count = 0`, `pass = 1`.
- `z_in` stuck at 0 with `err_in = (z_in != TRUTH[x])` → `captured = 8'h00`, `err_count = 4`, `pass = 0`.
- `z_in = ~TRUTH[x]`, `err_in = 0`:
  - With the macro defined → `err_count = 8`, `captured = 8'hC6`, `pass = 0`.
  - Without the macro → `err_count = 0`, `pass = 0`.
- `start` pulsed again while `x = 3` → ignored, and the sweep completes normally. Then `reset` asserted at `x = 5` → `x = 0`, `busy = 0`, no `done`. A new `start` → sweep restarts from `x = 0` with cleared results.
- `SETTLE = 3`, ideal stage → each `x` value held 4 cycles; `done` after edge 33; `pass = 1`.
